// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and idle pin levels for the SPI initiator
package spi_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;
    localparam logic SPI_IDLE_SCK  = 1'b0;
    localparam logic SPI_IDLE_CS_N = 1'b1;
endpackage

// File: rtl/spi_phase_timer.sv
// spi_phase_timer: loadable down-counter flagging the last cycle of a timed phase
module spi_phase_timer #(
    parameter int CW = 3
) (
    input  logic          clk_in,
    input  logic          reset_in,
    input  logic          load_in,
    input  logic [CW-1:0] load_val_in,
    output logic          tc_out
);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk_in or posedge reset_in)
        if (reset_in) cnt <= '0;
        else if (load_in) cnt <= load_val_in;
        else if (cnt != '0) cnt <= cnt - CW'(1);
    assign tc_out = cnt == '0;
endmodule

// File: rtl/spi_master_tx.sv
// spi_master_tx: mode-0 MSB-first SPI initiator with synchronized SDI capture
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int HALF_PERIOD = 4
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] tx_data_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] rx_data_out,
    output logic             sck_out,
    output logic             sdo_out,
    output logic             cs_n_out,
    input  logic             sdi_in
);
    localparam int CW = $clog2(HALF_PERIOD + 1);
    localparam int BW = $clog2(WIDTH + 1);
    state_t state, next;
    logic tc, load;
    logic [CW-1:0] load_val;
    logic [WIDTH-1:0] tx_sr, rx_sr;
    logic [BW-1:0] bit_cnt;
    logic sdi_meta, sdi_sync;
    spi_phase_timer #(.CW(CW)) u_timer (
        .clk_in(clk_in),
        .reset_in(reset_in),
        .load_in(load),
        .load_val_in(load_val),
        .tc_out(tc)
    );
    // SETUP stands in for bit 0's low phase, so it hands over straight to HIGH
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start_in ? SETUP : IDLE;
            SETUP:   next = tc ? HIGH : SETUP;
            LOW:     next = tc ? HIGH : LOW;
            HIGH:    next = !tc ? HIGH : (bit_cnt == BW'(WIDTH - 1)) ? HOLD : LOW;
            HOLD:    next = tc ? GAP : HOLD;
            GAP:     next = tc ? IDLE : GAP;
            default: next = IDLE;
        endcase
        load = next != state;
        // GAP runs one extra cycle to cover the done pulse
        load_val = (next == GAP) ? CW'(HALF_PERIOD) : CW'(HALF_PERIOD - 1);
    end
    always_ff @(posedge clk_in or posedge reset_in)
        if (reset_in) begin
            state <= IDLE;
            {sdi_sync, sdi_meta} <= 2'b00;
            tx_sr <= '0;
            rx_sr <= '0;
            bit_cnt <= '0;
            rx_data_out <= '0;
            done_out <= 1'b0;
            busy_out <= 1'b0;
            sck_out <= SPI_IDLE_SCK;
            cs_n_out <= SPI_IDLE_CS_N;
        end else begin
            state <= next;
            {sdi_sync, sdi_meta} <= {sdi_meta, sdi_in};
            sck_out <= next == HIGH;
            cs_n_out <= (next == IDLE) || (next == GAP);
            busy_out <= next != IDLE;
            done_out <= (state == HOLD) && tc;
            if ((state == IDLE) && start_in) begin
                tx_sr <= tx_data_in;
                rx_sr <= '0;
                bit_cnt <= '0;
            end
            if (((state == SETUP) || (state == LOW)) && tc) rx_sr <= (rx_sr << 1) | WIDTH'(sdi_sync);
            if ((state == HIGH) && tc) begin
                bit_cnt <= bit_cnt + BW'(1);
                if (next == LOW) tx_sr <= tx_sr << 1;
            end
            if ((state == HOLD) && tc) begin
                rx_data_out <= rx_sr;
                tx_sr <= '0;
            end
        end
    assign sdo_out = tx_sr[WIDTH-1];
endmodule

// File: tb/tb_spi_master_tx.sv
// tb_spi_master_tx: directed and randomized frames against an SPI slave model
module tb_spi_master_tx;
    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;
    logic reset_in, start0, start1, loop0;
    logic [31:0] tx0, rx0, slave_word, s_out, s_in;
    logic busy0, done0, sck0, sdo0, cs0, sdi0;
    logic [0:0] tx1, rx1;
    logic busy1, done1, sck1, sdo1, cs1;
    int passed = 0, total = 0;
    assign sdi0 = loop0 ? sdo0 : s_out[31];
    spi_master_tx dut0 (
        .clk_in(clk_in), .reset_in(reset_in), .start_in(start0), .tx_data_in(tx0),
        .busy_out(busy0), .done_out(done0), .rx_data_out(rx0), .sck_out(sck0),
        .sdo_out(sdo0), .cs_n_out(cs0), .sdi_in(sdi0)
    );
    spi_master_tx #(.WIDTH(1), .HALF_PERIOD(3)) dut1 (
        .clk_in(clk_in), .reset_in(reset_in), .start_in(start1), .tx_data_in(tx1),
        .busy_out(busy1), .done_out(done1), .rx_data_out(rx1), .sck_out(sck1),
        .sdo_out(sdo1), .cs_n_out(cs1), .sdi_in(sdo1)
    );
    always @(negedge cs0) begin
        s_out = slave_word;
        s_in = 32'h0;
    end
    always @(negedge sck0) s_out = s_out << 1;
    always @(posedge sck0) s_in = {s_in[30:0], sdo0};
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask
    task automatic frame0(input logic [31:0] tx, input logic [31:0] sw, input logic lb, input int poke,
                          output int busy_n, output int done_n, output int rises);
        logic ps;
        @(negedge clk_in);
        tx0 = tx;
        slave_word = sw;
        loop0 = lb;
        start0 = 1'b1;
        @(negedge clk_in);
        start0 = 1'b0;
        tx0 = $urandom;
        busy_n = 0;
        done_n = 0;
        rises = 0;
        ps = 1'b0;
        for (int i = 0; i < 2000 && busy0; i++) begin
            busy_n++;
            done_n += int'(done0);
            rises += int'(sck0 && !ps);
            ps = sck0;
            start0 = (busy_n == poke);
            if (busy_n == poke) tx0 = $urandom;
            @(negedge clk_in);
        end
        start0 = 1'b0;
    endtask
    initial begin
        int b, d, r, run, minrun, any;
        logic [31:0] t, w;
        logic lb, ps;
        reset_in = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        loop0 = 1'b1;
        tx0 = 32'h0;
        tx1 = 1'b0;
        slave_word = 32'h0;
        repeat (3) @(negedge clk_in);
        chk("rst_cs_n", cs0, 1);
        chk("rst_sck", sck0, 0);
        chk("rst_sdo", sdo0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_rx", rx0, 0);
        reset_in = 1'b0;
        frame0(32'hA5C3_0F81, 32'h0, 1'b1, 0, b, d, r);
        chk("lb_rx", rx0, 32'hA5C3_0F81);
        chk("lb_done_cycles", d, 1);
        chk("lb_busy_cycles", b, 265);
        chk("lb_sck_rises", r, 32);
        chk("lb_slave_cap", s_in, 32'hA5C3_0F81);
        frame0(32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 0, b, d, r);
        chk("slv_rx", rx0, 32'hDEAD_BEEF);
        chk("slv_cap", s_in, 32'h1234_5678);
        chk("slv_busy_cycles", b, 265);
        @(negedge clk_in);
        tx0 = $urandom;
        start0 = 1'b1;
        @(negedge clk_in);
        start0 = 1'b0;
        any = 0;
        for (int i = 0; i < 85; i++) begin
            any += int'(done0);
            @(negedge clk_in);
        end
        chk("mid_sck_high", sck0, 1);
        reset_in = 1'b1;
        #1;
        chk("mid_rst_cs_n", cs0, 1);
        chk("mid_rst_sck", sck0, 0);
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_done", done0 | (any != 0), 0);
        chk("mid_rst_rx", rx0, 0);
        @(negedge clk_in);
        reset_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            t = $urandom;
            w = $urandom;
            lb = 1'($urandom_range(0, 1));
            frame0(t, w, lb, 0, b, d, r);
            chk("rnd_rx", rx0, lb ? t : w);
            chk("rnd_cap", s_in, t);
            chk("rnd_done_cycles", d, 1);
        end
        t = $urandom;
        frame0(t, 32'h0, 1'b1, 100, b, d, r);
        chk("poke_rx", rx0, t);
        chk("poke_done_cycles", d, 1);
        any = 0;
        repeat (6) begin
            @(negedge clk_in);
            any += int'(busy0);
        end
        chk("poke_not_queued", any, 0);
        loop0 = 1'b1;
        tx0 = 32'h0F0F_3C3C;
        start0 = 1'b1;
        d = 0;
        run = 0;
        minrun = 9999;
        any = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk_in);
            if (cs0) run++;
            else begin
                if (any != 0 && run > 0 && run < minrun) minrun = run;
                run = 0;
            end
            if (done0) begin
                any = 1;
                d++;
            end
        end
        start0 = 1'b0;
        chk("hold_frames", d >= 2, 1);
        chk("hold_gap", minrun >= 4 && minrun < 9999, 1);
        chk("hold_rx", rx0, 32'h0F0F_3C3C);
        for (int i = 0; i < 400 && busy0; i++) @(negedge clk_in);
        chk("hold_idle", busy0, 0);
        for (int k = 0; k < 2; k++) begin
            tx1 = 1'(1 - k);
            start1 = 1'b1;
            @(negedge clk_in);
            start1 = 1'b0;
            tx1 = 1'(k);
            b = 0;
            r = 0;
            run = 0;
            ps = 1'b0;
            for (int i = 0; i < 100 && busy1; i++) begin
                b++;
                r += int'(sck1 && !ps);
                run += int'(sck1);
                ps = sck1;
                @(negedge clk_in);
            end
            chk("w1_rx", rx1, 32'(1 - k));
            chk("w1_busy_cycles", b, 13);
            chk("w1_sck_rises", r, 1);
            chk("w1_sck_width", run, 3);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
